// File: rtl/kasumi_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : kasumi_mem_pkg
//  Description : Shared types and width helpers for the memory-fill blocks.
//  Revision    : 1.0 - initial release
// ============================================================================
package kasumi_mem_pkg;

  // Line-fill controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_HOLD = 2'd2
  } fill_state_e;

  // Bits needed to index n items, never less than 1 so single-entry
  // configurations still get a real vector.
  function automatic int calc_width(input int n);
    calc_width = (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage : kasumi_mem_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Round-robin arbiter. The search starts at the channel after
//                the last accepted grant; channel 0 has first priority out of
//                reset. The pointer only advances when the grant is accepted.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int NUM_CH = 2,
  parameter int CW     = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] req_i,
  input  logic              accept_i,
  output logic [NUM_CH-1:0] gnt_o,
  output logic [CW-1:0]     gnt_idx_o
);

  logic [CW-1:0] ptr_q;
  logic [CW-1:0] ptr_d;
  logic [CW:0]   cand;
  logic [CW:0]   nxt;
  logic          found;

  // Scan channels starting at the pointer, wrapping modulo NUM_CH
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    cand      = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cand = {1'b0, ptr_q} + (CW+1)'(i);
      if (cand >= (CW+1)'(NUM_CH)) begin
        cand = cand - (CW+1)'(NUM_CH);
      end
      if (!found && req_i[cand[CW-1:0]]) begin
        found     = 1'b1;
        gnt_idx_o = cand[CW-1:0];
      end
    end
    if (found) begin
      gnt_o[gnt_idx_o] = 1'b1;
    end
  end

  // Next pointer is the channel after the accepted grant
  always_comb begin
    ptr_d = ptr_q;
    nxt   = {1'b0, gnt_idx_o} + (CW+1)'(1);
    if (nxt >= (CW+1)'(NUM_CH)) begin
      nxt = '0;
    end
    if (accept_i && found) begin
      ptr_d = nxt[CW-1:0];
    end
  end

  // Pointer register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/line_fill_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : line_fill_arbiter
//  Description : Arbitrates line-fill requests from several cache channels,
//                streams BEATS beats of a line from memory and writes them
//                into the granted channel's line buffer with one cycle of
//                latency. A completed request is held until it is dropped so
//                it cannot be served twice.
//  Revision    : 1.0 - initial release
// ============================================================================
module line_fill_arbiter
  import kasumi_mem_pkg::*;
#(
  parameter int  NUM_CH = 2,
  parameter int  BEATS  = 64,
  parameter int  IDX_W  = 2,
  parameter int  DATA_W = 512,
  localparam int BW     = calc_width(BEATS),
  localparam int CW     = calc_width(NUM_CH)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_CH-1:0]         req,
  input  logic [NUM_CH*IDX_W-1:0]   req_idx,
  input  logic [DATA_W-1:0]         mem_rdata,
  input  logic                      mem_rvalid,
  output logic                      mem_req,
  output logic [CW+IDX_W+BW-1:0]    mem_raddr,
  output logic [NUM_CH-1:0]         wr_line,
  output logic [IDX_W+BW-1:0]       wr_addr,
  output logic [DATA_W-1:0]         wr_data,
  output logic [NUM_CH-1:0]         done,
  output logic                      busy
);

  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  fill_state_e          state_q, state_d;
  logic [NUM_CH-1:0]    gnt_oh_q, gnt_oh_d;
  logic [CW-1:0]        gnt_idx_q, gnt_idx_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [BW-1:0]        beat_q, beat_d;
  logic [NUM_CH-1:0]    wr_line_q, wr_line_d;
  logic [IDX_W+BW-1:0]  wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]    wr_data_q, wr_data_d;
  logic [NUM_CH-1:0]    done_q, done_d;

  logic [NUM_CH-1:0]    arb_gnt;
  logic [CW-1:0]        arb_idx;
  logic                 arb_accept;
  logic [IDX_W-1:0]     sel_idx;
  logic                 req_held;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .CW     (CW)
  ) u_rr_arbiter (
    .clk       (clk),
    .reset     (reset),
    .req_i     (req),
    .accept_i  (arb_accept),
    .gnt_o     (arb_gnt),
    .gnt_idx_o (arb_idx)
  );

  // Pick the line index of whichever channel the arbiter is offering
  always_comb begin
    sel_idx = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (arb_idx == CW'(c)) begin
        sel_idx = req_idx[c*IDX_W +: IDX_W];
      end
    end
  end

  // The granted channel still wants its line
  assign req_held = |(req & gnt_oh_q);

  // Next-state and registered-output logic of the fill sequencer
  always_comb begin
    state_d    = state_q;
    gnt_oh_d   = gnt_oh_q;
    gnt_idx_d  = gnt_idx_q;
    idx_d      = idx_q;
    beat_d     = beat_q;
    wr_line_d  = '0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    done_d     = '0;
    arb_accept = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          arb_accept = 1'b1;
          gnt_oh_d   = arb_gnt;
          gnt_idx_d  = arb_idx;
          idx_d      = sel_idx;
          beat_d     = '0;
          state_d    = ST_FILL;
        end
      end
      ST_FILL: begin
        // A withdrawn request abandons the line; written beats are kept
        if (!req_held) begin
          state_d = ST_IDLE;
        end else if (mem_rvalid) begin
          wr_line_d = gnt_oh_q;
          wr_addr_d = {idx_q, beat_q};
          wr_data_d = mem_rdata;
          if (beat_q == LAST_BEAT) begin
            done_d  = gnt_oh_q;
            state_d = ST_HOLD;
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end
      end
      ST_HOLD: begin
        if (!req_held) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      gnt_oh_q  <= '0;
      gnt_idx_q <= '0;
      idx_q     <= '0;
      beat_q    <= '0;
      wr_line_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= '0;
    end else begin
      state_q   <= state_d;
      gnt_oh_q  <= gnt_oh_d;
      gnt_idx_q <= gnt_idx_d;
      idx_q     <= idx_d;
      beat_q    <= beat_d;
      wr_line_q <= wr_line_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
    end
  end

  assign mem_req   = (state_q == ST_FILL);
  assign busy      = (state_q != ST_IDLE);
  assign mem_raddr = {gnt_idx_q, idx_q, beat_q};
  assign wr_line   = wr_line_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign done      = done_q;

endmodule : line_fill_arbiter
`default_nettype wire

// File: tb/tb_line_fill_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_line_fill_arbiter
//  Description : Directed self-checking bench for line_fill_arbiter, default
//                configuration plus a 4-channel / 8-beat configuration.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_line_fill_arbiter;

  logic clk;
  logic reset;

  // Default configuration: NUM_CH=2, BEATS=64, IDX_W=2, DATA_W=512
  logic [1:0]   req_a;
  logic [3:0]   req_idx_a;
  logic [511:0] mem_rdata_a;
  logic         mem_rvalid_a;
  logic         mem_req_a;
  logic [8:0]   mem_raddr_a;
  logic [1:0]   wr_line_a;
  logic [7:0]   wr_addr_a;
  logic [511:0] wr_data_a;
  logic [1:0]   done_a;
  logic         busy_a;

  // Sweep configuration: NUM_CH=4, BEATS=8, IDX_W=3, DATA_W=16
  logic [3:0]   req_b;
  logic [11:0]  req_idx_b;
  logic [15:0]  mem_rdata_b;
  logic         mem_rvalid_b;
  logic         mem_req_b;
  logic [7:0]   mem_raddr_b;
  logic [3:0]   wr_line_b;
  logic [5:0]   wr_addr_b;
  logic [15:0]  wr_data_b;
  logic [3:0]   done_b;
  logic         busy_b;

  int n_vec = 0;
  int n_err = 0;

  line_fill_arbiter dut_a (
    .clk        (clk),
    .reset      (reset),
    .req        (req_a),
    .req_idx    (req_idx_a),
    .mem_rdata  (mem_rdata_a),
    .mem_rvalid (mem_rvalid_a),
    .mem_req    (mem_req_a),
    .mem_raddr  (mem_raddr_a),
    .wr_line    (wr_line_a),
    .wr_addr    (wr_addr_a),
    .wr_data    (wr_data_a),
    .done       (done_a),
    .busy       (busy_a)
  );

  line_fill_arbiter #(
    .NUM_CH (4),
    .BEATS  (8),
    .IDX_W  (3),
    .DATA_W (16)
  ) dut_b (
    .clk        (clk),
    .reset      (reset),
    .req        (req_b),
    .req_idx    (req_idx_b),
    .mem_rdata  (mem_rdata_b),
    .mem_rvalid (mem_rvalid_b),
    .mem_req    (mem_req_b),
    .mem_raddr  (mem_raddr_b),
    .wr_line    (wr_line_b),
    .wr_addr    (wr_addr_b),
    .wr_data    (wr_data_b),
    .done       (done_b),
    .busy       (busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] pat(input int b, input int s);
    logic [31:0] w;
    w   = 32'(b) ^ (32'(s) * 32'h1357_9BDF) ^ 32'hA5A5_0000;
    pat = {16{w}};
  endfunction

  function automatic logic [15:0] pat16(input int b, input int s);
    pat16 = 16'((b * 32'h111) ^ (s * 32'h1000) ^ 32'h5A00);
  endfunction

  task automatic zeros_a(input string tag);
    chk({tag, "_mem_req"},   512'(mem_req_a),   512'(0));
    chk({tag, "_mem_raddr"}, 512'(mem_raddr_a), 512'(0));
    chk({tag, "_wr_line"},   512'(wr_line_a),   512'(0));
    chk({tag, "_wr_addr"},   512'(wr_addr_a),   512'(0));
    chk({tag, "_wr_data"},   wr_data_a,         512'(0));
    chk({tag, "_done"},      512'(done_a),      512'(0));
    chk({tag, "_busy"},      512'(busy_a),      512'(0));
  endtask

  // Entered with the fill just granted (beat 0); runs nb accepted beats.
  task automatic fill_a(input int ch, input int idx, input bit stall, input int nb);
    logic [1:0] oh;
    oh = 2'b01 << ch;
    for (int b = 0; b < nb; b++) begin
      chk("a_mem_req", 512'(mem_req_a), 512'(1));
      chk("a_raddr", 512'(mem_raddr_a), 512'((ch << 8) | (idx << 6) | b));
      mem_rvalid_a = 1'b1;
      mem_rdata_a  = pat(b, ch + idx);
      step();
      chk("a_wr_line", 512'(wr_line_a), 512'(oh));
      chk("a_wr_addr", 512'(wr_addr_a), 512'((idx << 6) | b));
      chk("a_wr_data", wr_data_a, pat(b, ch + idx));
      chk("a_done", 512'(done_a), (b == 63) ? 512'(oh) : 512'(0));
      if (stall && b != 63) begin
        mem_rvalid_a = 1'b0;
        mem_rdata_a  = ~pat(b, ch + idx);
        step();
        chk("a_stall_wr_line", 512'(wr_line_a), 512'(0));
        chk("a_stall_done", 512'(done_a), 512'(0));
        chk("a_stall_raddr", 512'(mem_raddr_a), 512'((ch << 8) | (idx << 6) | (b + 1)));
      end
    end
    mem_rvalid_a = 1'b0;
  endtask

  task automatic hold_a(input int n);
    chk("a_hold_mem_req", 512'(mem_req_a), 512'(0));
    chk("a_hold_busy", 512'(busy_a), 512'(1));
    for (int i = 0; i < n; i++) begin
      step();
      chk("a_hold_wr_line", 512'(wr_line_a), 512'(0));
      chk("a_hold_done", 512'(done_a), 512'(0));
      chk("a_hold_busy2", 512'(busy_a), 512'(1));
    end
  endtask

  task automatic fill_b(input int ch, input int idx);
    logic [3:0] oh;
    oh = 4'b0001 << ch;
    for (int b = 0; b < 8; b++) begin
      chk("b_raddr", 512'(mem_raddr_b), 512'((ch << 6) | (idx << 3) | b));
      mem_rvalid_b = 1'b1;
      mem_rdata_b  = pat16(b, ch);
      step();
      chk("b_wr_line", 512'(wr_line_b), 512'(oh));
      chk("b_wr_addr", 512'(wr_addr_b), 512'((idx << 3) | b));
      chk("b_wr_data", 512'(wr_data_b), 512'(pat16(b, ch)));
      chk("b_done", 512'(done_b), (b == 7) ? 512'(oh) : 512'(0));
    end
    mem_rvalid_b = 1'b0;
    chk("b_hold_mem_req", 512'(mem_req_b), 512'(0));
    chk("b_hold_busy", 512'(busy_b), 512'(1));
  endtask

  initial begin
    int ch;
    int idx;
    reset        = 1'b1;
    req_a        = '0;
    req_idx_a    = '0;
    mem_rdata_a  = '0;
    mem_rvalid_a = 1'b0;
    req_b        = '0;
    req_idx_b    = '0;
    mem_rdata_b  = '0;
    mem_rvalid_b = 1'b0;
    #1 reset = 1'b0;
    repeat (3) step();

    // Reset state
    zeros_a("rst");
    chk("rst_b_busy", 512'(busy_b), 512'(0));
    chk("rst_b_raddr", 512'(mem_raddr_b), 512'(0));
    chk("rst_b_wr_line", 512'(wr_line_b), 512'(0));
    reset = 1'b1;
    step();
    chk("idle_busy", 512'(busy_a), 512'(0));

    // Single fill on channel 1, index 2
    req_idx_a = {2'd2, 2'd0};
    req_a     = 2'b10;
    step();
    chk("single_busy", 512'(busy_a), 512'(1));
    fill_a(1, 2, 1'b0, 64);
    hold_a(3);
    req_a = 2'b00;
    step();
    chk("single_idle", 512'(busy_a), 512'(0));

    // Stalled fill on channel 0; index change after grant is ignored
    req_idx_a = {2'd0, 2'd1};
    req_a     = 2'b01;
    step();
    req_idx_a = {2'd3, 2'd2};
    fill_a(0, 1, 1'b1, 64);
    hold_a(1);
    req_a = 2'b00;
    step();
    chk("stall_idle", 512'(busy_a), 512'(0));

    // Reset in the middle of a fill
    req_idx_a = {2'd2, 2'd0};
    req_a     = 2'b10;
    step();
    fill_a(1, 2, 1'b0, 30);
    chk("rst_mid_beat30", 512'(mem_raddr_a), 512'((1 << 8) | (2 << 6) | 30));
    reset = 1'b0;
    #1;
    zeros_a("rst_mid");
    step();
    zeros_a("rst_mid_held");
    reset = 1'b1;
    step();
    fill_a(1, 2, 1'b0, 64);
    hold_a(1);
    req_a = 2'b00;
    step();
    chk("rst_mid_idle", 512'(busy_a), 512'(0));

    // Fairness: both channels requesting, each re-raised after done
    req_idx_a = {2'd3, 2'd1};
    req_a     = 2'b11;
    step();
    for (int k = 0; k < 4; k++) begin
      ch  = k % 2;
      idx = (ch == 0) ? 1 : 3;
      fill_a(ch, idx, 1'b0, 64);
      hold_a(1);
      req_a[ch] = 1'b0;
      step();
      chk("fair_idle", 512'(busy_a), 512'(0));
      req_a[ch] = 1'b1;
      step();
    end

    // Abort: channel 0 granted again, dropped at beat 10
    fill_a(0, 1, 1'b0, 10);
    chk("abort_beat10", 512'(mem_raddr_a), 512'((0 << 8) | (1 << 6) | 10));
    req_a        = 2'b10;
    mem_rvalid_a = 1'b0;
    step();
    chk("abort_busy", 512'(busy_a), 512'(0));
    chk("abort_mem_req", 512'(mem_req_a), 512'(0));
    chk("abort_done", 512'(done_a), 512'(0));
    chk("abort_wr_line", 512'(wr_line_a), 512'(0));
    step();
    chk("abort_next_mem_req", 512'(mem_req_a), 512'(1));
    chk("abort_next_raddr", 512'(mem_raddr_a), 512'((1 << 8) | (3 << 6)));
    req_a = 2'b00;
    step();
    chk("abort_next_idle", 512'(busy_a), 512'(0));
    chk("abort_next_done", 512'(done_a), 512'(0));

    // Parameter sweep: 4 channels, 8 beats, 3-bit index
    req_idx_b = {3'd6, 3'd5, 3'd4, 3'd3};
    req_b     = 4'hF;
    step();
    for (int k = 0; k < 4; k++) begin
      fill_b(k, k + 3);
      req_b[k] = 1'b0;
      step();
      chk("b_idle", 512'(busy_b), 512'(0));
      req_b[k] = 1'b1;
      step();
    end
    chk("b_wrap_raddr", 512'(mem_raddr_b), 512'((0 << 6) | (3 << 3)));
    chk("b_wrap_mem_req", 512'(mem_req_b), 512'(1));
    req_b = 4'h0;
    step();
    chk("b_final_idle", 512'(busy_b), 512'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_line_fill_arbiter
`default_nettype wire
